// File: rtl/debounce_pkg.sv
// Shared types and default constants for the input debounce/synchroniser stage.
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } debounce_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage : debounce_pkg

// File: rtl/sync_ff_chain.sv
// Reusable N-deep flop chain for bringing a single asynchronous bit into the clk domain.
module sync_ff_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_reg;
    logic [DEPTH-1:0] stage_next;

    if (DEPTH < 2) begin : g_depth_check
        $error("sync_ff_chain: DEPTH must be at least 2");
    end

    // Stage 0 is the only flop that ever sees the raw asynchronous input.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign stage_next[gi] = d;
        end else begin : g_rest
            assign stage_next[gi] = stage_reg[gi-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign q = stage_reg[DEPTH-1];

endmodule : sync_ff_chain

// File: rtl/input_debounce_sync.sv
// Synchronise and debounce an asynchronous input into a clean level plus edge pulses.
// Define DEBOUNCE_EDGE_PULSE_EN to build the rise/fall pulse registers; otherwise they read 0.
module input_debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("input_debounce_sync: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_cycles_check
        $error("input_debounce_sync: DEBOUNCE_CYCLES must be at least 1");
    end

    logic din_s;

    sync_ff_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    debounce_state_t  state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dout_reg, dout_next;
    logic             accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
            dout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
        end
    end

    // cnt counts consecutive disagreeing samples already seen, so the sample
    // that finds cnt == DEBOUNCE_CYCLES-1 is the one that completes the run.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            STABLE: begin
                cnt_next = '0;
                if (din_s != dout_reg) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_next = CHECK;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            CHECK: begin
                if (din_s == dout_reg) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    accept     = 1'b1;
                    state_next = STABLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
        dout_next = dout_reg ^ accept;
    end

    assign dout = dout_reg;
    assign busy = (state_reg == CHECK);

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_reg, rise_next;
    logic fall_reg, fall_next;

    // Pulses register alongside dout so they line up with the level change.
    assign rise_next = accept & ~dout_reg;
    assign fall_next = accept &  dout_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule : input_debounce_sync

// File: tb/tb_input_debounce_sync.sv
// Directed bench for input_debounce_sync: default instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_input_debounce_sync;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic din  = 1'b0;
    logic din1 = 1'b0;
    logic dout, rise, fall, busy;
    logic dout1, rise1, fall1, busy1;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    typedef struct {
        int         tgt;
        string      tag;
        logic [3:0] e0;
        logic [3:0] e1;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    input_debounce_sync dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    input_debounce_sync #(
        .DEBOUNCE_CYCLES (1)
    ) dut1 (
        .clk  (clk),
        .rst  (rst),
        .din  (din1),
        .dout (dout1),
        .rise (rise1),
        .fall (fall1),
        .busy (busy1)
    );

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Expected {dout, rise, fall, busy}; pulses read 0 when the pulse logic is not built.
    function automatic logic [3:0] mk(input logic d, input logic r, input logic f, input logic b);
        return {d, r & PE, f & PE, b};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Scoreboard: each entry is checked on the negedge after the edge it targets.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].tgt == edge_cnt) begin
            e = q.pop_front();
            $display("edge %0d %s dut=%b dut1=%b", edge_cnt, e.tag,
                     {dout, rise, fall, busy}, {dout1, rise1, fall1, busy1});
            check({e.tag, "/dut"},  {dout, rise, fall, busy},     e.e0);
            check({e.tag, "/dut1"}, {dout1, rise1, fall1, busy1}, e.e1);
        end
    end

    task automatic cyc(input string tag, input logic dv, input logic d1v,
                       input logic [3:0] e0, input logic [3:0] e1);
        exp_t e;
        din  = dv;
        din1 = d1v;
        e.tgt = edge_cnt + 1;
        e.tag = tag;
        e.e0  = e0;
        e.e1  = e1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] z;
        z = 4'b0000;

        // Asynchronous assertion clears everything without a clock edge.
        #1 rst = 1'b0;
        #1;
        check("rst_async/dut",  {dout, rise, fall, busy},     z);
        check("rst_async/dut1", {dout1, rise1, fall1, busy1}, z);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            cyc("rst_hold", i[0], ~i[0], z, z);
        end

        rst = 1'b1;
        cyc("idle", 1'b0, 1'b0, z, z);
        cyc("idle", 1'b0, 1'b0, z, z);

        // Clean rise: din=1 before edge 1.
        cyc("rise_e1", 1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("rise_e2", 1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("rise_e3", 1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("rise_e4", 1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("rise_e5", 1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("rise_e6", 1'b1, 1'b0, mk(1,1,0,0), z);
        cyc("rise_e7", 1'b1, 1'b0, mk(1,0,0,0), z);

        // Bounce then settle low: 0,1,0,0,0,0 then hold 0.
        cyc("bnc_e1", 1'b0, 1'b0, mk(1,0,0,0), z);
        cyc("bnc_e2", 1'b1, 1'b0, mk(1,0,0,0), z);
        cyc("bnc_e3", 1'b0, 1'b0, mk(1,0,0,1), z);
        cyc("bnc_e4", 1'b0, 1'b0, mk(1,0,0,0), z);
        cyc("bnc_e5", 1'b0, 1'b0, mk(1,0,0,1), z);
        cyc("bnc_e6", 1'b0, 1'b0, mk(1,0,0,1), z);
        cyc("bnc_e7", 1'b0, 1'b0, mk(1,0,0,1), z);
        cyc("bnc_e8", 1'b0, 1'b0, mk(0,0,1,0), z);
        cyc("bnc_e9", 1'b0, 1'b0, mk(0,0,0,0), z);

        // Glitch of 3 cycles is rejected.
        cyc("gl_e1", 1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("gl_e2", 1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("gl_e3", 1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("gl_e4", 1'b0, 1'b0, mk(0,0,0,1), z);
        cyc("gl_e5", 1'b0, 1'b0, mk(0,0,0,1), z);
        cyc("gl_e6", 1'b0, 1'b0, mk(0,0,0,0), z);
        cyc("gl_e7", 1'b0, 1'b0, mk(0,0,0,0), z);

        // Exactly 4 cycles high is accepted; the following low is accepted too.
        cyc("ex_e1",  1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("ex_e2",  1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("ex_e3",  1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("ex_e4",  1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("ex_e5",  1'b0, 1'b0, mk(0,0,0,1), z);
        cyc("ex_e6",  1'b0, 1'b0, mk(1,1,0,0), z);
        cyc("ex_e7",  1'b0, 1'b0, mk(1,0,0,1), z);
        cyc("ex_e8",  1'b0, 1'b0, mk(1,0,0,1), z);
        cyc("ex_e9",  1'b0, 1'b0, mk(1,0,0,1), z);
        cyc("ex_e10", 1'b0, 1'b0, mk(0,0,1,0), z);
        cyc("ex_e11", 1'b0, 1'b0, mk(0,0,0,0), z);

        // Reset while qualifying with cnt=2.
        cyc("mid_e1", 1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("mid_e2", 1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("mid_e3", 1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("mid_e4", 1'b1, 1'b0, mk(0,0,0,1), z);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid/dut", {dout, rise, fall, busy}, z);
        @(posedge clk);
        #1;
        cyc("mid_hold", 1'b1, 1'b0, z, z);
        cyc("mid_hold", 1'b1, 1'b0, z, z);
        rst = 1'b1;
        cyc("rel_e1", 1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("rel_e2", 1'b1, 1'b0, mk(0,0,0,0), z);
        cyc("rel_e3", 1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("rel_e4", 1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("rel_e5", 1'b1, 1'b0, mk(0,0,0,1), z);
        cyc("rel_e6", 1'b1, 1'b0, mk(1,1,0,0), z);
        cyc("rel_e7", 1'b1, 1'b0, mk(1,0,0,0), z);

        // DEBOUNCE_CYCLES=1 instance follows din at edge 3.
        cyc("dc1_r1", 1'b1, 1'b1, mk(1,0,0,0), mk(0,0,0,0));
        cyc("dc1_r2", 1'b1, 1'b1, mk(1,0,0,0), mk(0,0,0,0));
        cyc("dc1_r3", 1'b1, 1'b1, mk(1,0,0,0), mk(1,1,0,0));
        cyc("dc1_r4", 1'b1, 1'b1, mk(1,0,0,0), mk(1,0,0,0));
        cyc("dc1_f1", 1'b1, 1'b0, mk(1,0,0,0), mk(1,0,0,0));
        cyc("dc1_f2", 1'b1, 1'b0, mk(1,0,0,0), mk(1,0,0,0));
        cyc("dc1_f3", 1'b1, 1'b0, mk(1,0,0,0), mk(0,0,1,0));
        cyc("dc1_f4", 1'b1, 1'b0, mk(1,0,0,0), mk(0,0,0,0));

        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL drain observed=%0d expected=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_input_debounce_sync

// File: doc/input_debounce_sync.md
# input_debounce_sync

Input conditioning stage that sits directly upstream of the team's D flip-flop stages and drives their `d` input. It synchronises an asynchronous, possibly bouncing input `din` into the `clk` domain and filters it with a consecutive-sample debounce counter. It presents a clean level `dout`, plus one-cycle `rise`/`fall` pulses for downstream edge-triggered logic.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flop count; must be ≥2 (elaboration-time check).
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples required to accept a new level; must be ≥1.
- `CNT_W`, derived as `$clog2(DEBOUNCE_CYCLES+1)`: counter width; not overridden.

Ports:
- `clk`, input, 1: single clock; all flops use the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low (assert 0, release 1).
- `din`, input, 1: raw asynchronous input.
- `dout`, output, 1: debounced level; registered.
- `rise`, output, 1: one-cycle pulse on a 0→1 change of `dout`; registered.
- `fall`, output, 1: one-cycle pulse on a 1→0 change of `dout`; registered.
- `busy`, output, 1: high while a candidate change is being qualified (state CHECK).

## Operation
- Synchroniser: `din` passes through a SYNC_STAGES-deep flop chain. `din_s` is the last stage. Nothing else samples `din`.
- FSM states are STABLE and CHECK, with counter `cnt` [CNT_W-1:0].
- STABLE:
  - If `din_s != dout`, go to CHECK and set `cnt=1`.
  - Otherwise stay in STABLE with `cnt=0`.
- CHECK:
  - If `din_s == dout` (bounce back), return to STABLE with `cnt=0`. `dout` is unchanged.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, toggle `dout`, pulse `rise` or `fall`, return to STABLE and set `cnt=0`.
  - Otherwise, increment `cnt`.
- Special case DEBOUNCE_CYCLES=1: the STABLE→CHECK transition itself accepts the change. `dout` toggles on the edge where `din_s != dout` is first seen, and CHECK is never entered.
- `cnt` never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- `rise` and `fall` are mutually exclusive. Each is high for exactly one cycle and coincides with the `dout` update.
- `busy = (state == CHECK)`.
- Reset (asynchronous, `rst=0`):
  - All synchroniser flops = 0.
  - State = STABLE, `cnt=0`.
  - `dout=0`, `rise=0`, `fall=0`, `busy=0`.
- Reset asserted mid-CHECK aborts qualification immediately. No pulse is emitted.

## Timing
- Edge 1 is the first rising edge that samples a new `din` value.
- Under that numbering, `din_s` updates at edge SYNC_STAGES.
- `dout`, `rise` and `fall` update at edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is edge 6.
- A level on `din_s` held fewer than DEBOUNCE_CYCLES consecutive edges produces no output change.
- Holding the level for exactly DEBOUNCE_CYCLES edges is accepted.
- After reset release with `din=1` held, `rise` fires at edge SYNC_STAGES+DEBOUNCE_CYCLES after release.
- No combinational path from any input to any output.

## Configuration
- Macro `DEBOUNCE_EDGE_PULSE_EN`.
  - Defined: the `rise`/`fall` pulse logic and registers are built as above.
  - Undefined: `rise` and `fall` are tied to constant 0, no pulse flops are inferred, and `dout`/`busy` behaviour is identical.

## Structure
- Shared package `debounce_pkg` holds:
  - the state enum type (STABLE, CHECK);
  - the default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
- One sub-module, `sync_ff_chain`:
  - parameterised depth;
  - asynchronous active-low reset to 0;
  - reusable by other stages.
- The FSM, counter and pulse logic live in the top module.

## Test plan
- Reset: hold `rst=0` while toggling `din` and `clk` -> `dout=0`, `rise=0`, `fall=0`, `busy=0` throughout.
- Clean rise with defaults: release reset, then set `din=1` before edge 1 and hold -> `busy` high at edges 3–5, `dout=1` and `rise=1` at edge 6, `rise=0` at edge 7.
- Glitch rejection: with `dout=0`, pulse `din=1` for 3 clock cycles -> `busy` asserts, then `dout` stays 0 and `rise`/`fall` are never high.
- Bounce then settle: with `dout=1`, apply `din` 0,1,0,0,0,0 (one value per cycle) -> the first CHECK aborts, `fall` pulses once, and `dout=0` 6 edges after the final 0→ transition.
- Reset mid-CHECK: with `busy=1` and `cnt=2`, assert `rst` asynchronously between edges -> outputs clear immediately, and after release no pulse appears until `din` qualifies again.
- Configuration: `DEBOUNCE_CYCLES=1`, with and without `DEBOUNCE_EDGE_PULSE_EN` -> `dout` follows `din` at edge 3. Pulses are present with the macro defined and constant 0 without it.
